vga_fb_write_ctrl: RTL and testbench
====================================

# vga_fb_write_ctrl

Write-port controller for the VGA frame buffer. It shares the buffer's single pixel write port between two requesters: a CPU-side single-pixel write port and an internal rectangle-fill/clear engine. It issues at most one registered write per cycle as (color, x, y, we). It sits between the PULPino peripheral bus glue and the frame-buffer write inputs, in the 50 MHz write clock domain.

## Interface
- HD, 1280, visible width in pixels
- VD, 1024, visible height in pixels
- CW, 11, coordinate width in bits
- clk50mhz_i  in  1  write-domain clock; all logic on its rising edge
- arstn_i  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  CPU write request; held with stable data until cpu_ack_o
- cpu_x_i / cpu_y_i  in  CW  CPU pixel coordinates
- cpu_color_i  in  2  CPU pixel color (color_t)
- cpu_ack_o  out  1  one-cycle pulse, coincident with the issued CPU write
- fill_start_i  in  1  one-cycle start pulse for a rectangle fill
- fill_x0_i / fill_y0_i  in  CW  rectangle origin
- fill_w_i / fill_h_i  in  CW+1  rectangle width and height in pixels
- fill_color_i  in  2  fill color
- clear_i  in  1  one-cycle pulse: fill 0,0,HD,VD with BLACK
- fill_busy_o  out  1  fill engine active
- fill_done_o  out  1  one-cycle completion pulse
- color_o  out  2  write color to the frame buffer
- addr_x_o / addr_y_o  out  CW  write coordinates
- we_o  out  1  write enable

## Operation
- All outputs are registered. Reset value of every output is 0. Reset aborts any fill, and no done pulse is issued.
- Engine FSM states:
  - IDLE: fill_start_i or clear_i latches the parameters. Clear wins if both are asserted in the same cycle; clear uses x0=0, y0=0, w=HD, h=VD, color BLACK. If w==0 or h==0, go to DONE with no writes. Otherwise go to RUN.
  - RUN: walks in raster order, x fastest: x0..x0+w-1, then y+1, through y0+h-1. Advances only on the cycles it is granted.
  - DONE: single cycle, then IDLE.
- fill_start_i and clear_i are ignored outside IDLE.
- Coordinate arithmetic: end points are x0+w-1 and y0+h-1, computed at CW+1 bits. The walker counters are CW+1 bits, and the output coordinates are their low CW bits.
- Arbitration: round-robin with a last-grant flag.
  - CPU is eligible when cpu_req_i=1 and cpu_ack_o=0. The CPU is never granted in its own ack cycle, so the maximum CPU rate is one write per 2 cycles.
  - Fill is eligible in RUN.
  - If both are eligible, grant the one not granted last. A single eligible requester is always granted.
- A grant at edge N makes we_o, color, x and y valid during cycle N+1. A CPU grant also raises cpu_ack_o in cycle N+1.
- fill_done_o is high in the same cycle as the we_o of the last fill pixel. For an empty rectangle it is high in the cycle after start, with no we_o. fill_busy_o falls in the following cycle.
- fill_busy_o is high from the cycle after an accepted start until it falls as above.

## Timing
- Request-to-write latency is 1 cycle.
- Fill-only throughput is 1 pixel/cycle. A full clear takes HD*VD = 1,310,720 write cycles.
- Under contention with a continuous CPU request, the grant sequence is F,C,F,C,…; no request is ever lost or duplicated.

## Configuration
- VGA_FB_CLIP_EN defined:
  - A granted write with x>=HD or y>=VD is issued with we_o=0.
  - The slot is still consumed: cpu_ack_o pulses and the fill walker advances.
  - fill_done_o timing is unchanged.
- VGA_FB_CLIP_EN undefined: every granted write drives we_o=1, with coordinates truncated to CW bits.

## Structure
- Package vga_pkg:
  - color_t enum of 2 bits: BLACK=0, WHITE=1, BLUE=2, GREEN=3.
  - HD/VD defaults and the CW constant.
  - fill FSM state enum.
- Sub-module vga_rect_walker: holds the latched rectangle, the x/y counters, the advance input, and the last-pixel flag. The arbiter and output registers stay in the top.

## Test plan
- Reset: hold arstn_i=0 mid-fill, then release → all outputs 0, FSM IDLE, no fill_done_o.
- CPU write x=5, y=7, WHITE → next cycle we_o=1, addr 5/7, color_o=1, cpu_ack_o=1; no second write while req is still held in the ack cycle.
- Fill x0=10, y0=20, w=3, h=2, BLUE → six consecutive writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), color 2; fill_done_o with the last write; busy low the next cycle.
- Fill w=4, h=1 with cpu_req_i held for 2 transactions → interleaved F,C,F,C,F,F; 4 fill writes and 2 acks total, no loss or duplication.
- Fill with w=0 (and, separately, h=0) → fill_done_o one cycle after start, we_o never high.
- CPU write x=1280 → with VGA_FB_CLIP_EN: cpu_ack_o=1, we_o=0. Without the macro: we_o=1, addr_x_o=1280.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame-buffer write path.
// Optional clipping of off-screen writes is enabled by defining VGA_FB_CLIP_EN.
package vga_pkg;

  localparam int HD_DEFAULT = 1280;
  localparam int VD_DEFAULT = 1024;
  localparam int CW_DEFAULT = 11;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vga_rect_walker.sv
// Raster walker for the fill engine: latches a rectangle and steps x fastest,
// one pixel per advance. Counters are one bit wider than the coordinates.
module vga_rect_walker
  import vga_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] y0_i,
  input  logic [CW:0]   w_i,
  input  logic [CW:0]   h_i,
  output logic [CW:0]   x_o,
  output logic [CW:0]   y_o,
  output logic          last_o
);

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic [CW-1:0] x0_q, x0_d;
  logic [CW:0]   x_end_q, x_end_d;
  logic [CW:0]   y_end_q, y_end_d;
  logic [CW:0]   x_q, x_d;
  logic [CW:0]   y_q, y_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    x_d     = x_q;
    y_d     = y_q;
    if (load_i) begin
      x0_d    = x0_i;
      x_end_d = {1'b0, x0_i} + w_i - ONE;
      y_end_d = {1'b0, y0_i} + h_i - ONE;
      x_d     = {1'b0, x0_i};
      y_d     = {1'b0, y0_i};
    end else if (advance_i) begin
      if (x_q == x_end_q) begin
        x_d = {1'b0, x0_q};
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == x_end_q) && (y_q == y_end_q);

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Frame-buffer write-port controller: round-robin between CPU pixel writes and
// the rectangle fill/clear engine. VGA_FB_CLIP_EN suppresses off-screen writes.
module vga_fb_write_ctrl
  import vga_pkg::*;
#(
  parameter int HD = HD_DEFAULT,
  parameter int VD = VD_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk50mhz_i,
  input  logic          arstn_i,
  input  logic          cpu_req_i,
  input  logic [CW-1:0] cpu_x_i,
  input  logic [CW-1:0] cpu_y_i,
  input  logic [1:0]    cpu_color_i,
  output logic          cpu_ack_o,
  input  logic          fill_start_i,
  input  logic [CW-1:0] fill_x0_i,
  input  logic [CW-1:0] fill_y0_i,
  input  logic [CW:0]   fill_w_i,
  input  logic [CW:0]   fill_h_i,
  input  logic [1:0]    fill_color_i,
  input  logic          clear_i,
  output logic          fill_busy_o,
  output logic          fill_done_o,
  output logic [1:0]    color_o,
  output logic [CW-1:0] addr_x_o,
  output logic [CW-1:0] addr_y_o,
  output logic          we_o
);

`ifdef VGA_FB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [CW:0] HD_C = (CW+1)'(HD);
  localparam logic [CW:0] VD_C = (CW+1)'(VD);

  fill_state_t   state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic          last_cpu_q, last_cpu_d;
  color_t        color_q, color_d;
  color_t        fill_color_q, fill_color_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  logic          start_any, load, empty;
  logic [CW-1:0] sel_x0, sel_y0;
  logic [CW:0]   sel_w, sel_h;
  logic [CW:0]   fx, fy;
  logic          flast;

  logic          cpu_elig, fill_elig, grant_cpu, grant_fill, granted, oob;
  logic [CW:0]   gx, gy;
  color_t        gcolor;

  // Clear takes priority over a simultaneous fill start.
  assign start_any = fill_start_i | clear_i;
  assign load      = (state_q == FILL_IDLE) && start_any;
  assign sel_x0    = clear_i ? '0   : fill_x0_i;
  assign sel_y0    = clear_i ? '0   : fill_y0_i;
  assign sel_w     = clear_i ? HD_C : fill_w_i;
  assign sel_h     = clear_i ? VD_C : fill_h_i;
  assign empty     = (sel_w == '0) || (sel_h == '0);

  vga_rect_walker #(.CW(CW)) u_walker (
    .clk       (clk50mhz_i),
    .rst_n     (arstn_i),
    .load_i    (load),
    .advance_i (grant_fill),
    .x0_i      (sel_x0),
    .y0_i      (sel_y0),
    .w_i       (sel_w),
    .h_i       (sel_h),
    .x_o       (fx),
    .y_o       (fy),
    .last_o    (flast)
  );

  // The CPU is masked in its own ack cycle so a held request is not re-issued.
  assign cpu_elig   = cpu_req_i && !ack_q;
  assign fill_elig  = (state_q == FILL_RUN);
  assign grant_cpu  = cpu_elig && (!fill_elig || !last_cpu_q);
  assign grant_fill = fill_elig && !grant_cpu;
  assign granted    = grant_cpu || grant_fill;

  assign gx     = grant_cpu ? {1'b0, cpu_x_i} : fx;
  assign gy     = grant_cpu ? {1'b0, cpu_y_i} : fy;
  assign gcolor = grant_cpu ? color_t'(cpu_color_i) : fill_color_q;
  assign oob    = (gx >= HD_C) || (gy >= VD_C);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fill_color_d = fill_color_q;
    last_cpu_d   = last_cpu_q;
    we_d         = granted && !(CLIP_EN && oob);
    ack_d        = grant_cpu;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;

    if (granted) begin
      x_d        = gx[CW-1:0];
      y_d        = gy[CW-1:0];
      color_d    = gcolor;
      last_cpu_d = grant_cpu;
    end

    case (state_q)
      FILL_IDLE: begin
        if (start_any) begin
          fill_color_d = clear_i ? BLACK : color_t'(fill_color_i);
          busy_d       = 1'b1;
          if (empty) begin
            state_d = FILL_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL_RUN;
          end
        end
      end
      FILL_RUN: begin
        // Done is raised together with the write of the last pixel.
        if (grant_fill && flast) begin
          state_d = FILL_DONE;
          done_d  = 1'b1;
        end
      end
      FILL_DONE: begin
        state_d = FILL_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = FILL_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50mhz_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= FILL_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      we_q         <= 1'b0;
      ack_q        <= 1'b0;
      last_cpu_q   <= 1'b1;
      color_q      <= BLACK;
      fill_color_q <= BLACK;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      last_cpu_q   <= last_cpu_d;
      color_q      <= color_d;
      fill_color_q <= fill_color_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign cpu_ack_o   = ack_q;
  assign fill_busy_o = busy_q;
  assign fill_done_o = done_q;
  assign we_o        = we_q;
  assign color_o     = color_q;
  assign addr_x_o    = x_q;
  assign addr_y_o    = y_q;

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Bench for vga_fb_write_ctrl: a pixel-index model predicts every output each
// cycle; directed tests pin the model with hand-computed write sequences.
module tb_vga_fb_write_ctrl;

  localparam int CW = 11;
  localparam int HD = 1280;
  localparam int VD = 1024;
  localparam int MASK = (1 << (CW + 1)) - 1;
`ifdef VGA_FB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arstn_i = 1'b0;
  logic          cpu_req_i = 1'b0;
  logic [CW-1:0] cpu_x_i = '0;
  logic [CW-1:0] cpu_y_i = '0;
  logic [1:0]    cpu_color_i = '0;
  logic          fill_start_i = 1'b0;
  logic [CW-1:0] fill_x0_i = '0;
  logic [CW-1:0] fill_y0_i = '0;
  logic [CW:0]   fill_w_i = '0;
  logic [CW:0]   fill_h_i = '0;
  logic [1:0]    fill_color_i = '0;
  logic          clear_i = 1'b0;
  logic          cpu_ack_o, fill_busy_o, fill_done_o, we_o;
  logic [1:0]    color_o;
  logic [CW-1:0] addr_x_o, addr_y_o;

  vga_fb_write_ctrl dut (
    .clk50mhz_i   (clk),
    .arstn_i      (arstn_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_x_i      (cpu_x_i),
    .cpu_y_i      (cpu_y_i),
    .cpu_color_i  (cpu_color_i),
    .cpu_ack_o    (cpu_ack_o),
    .fill_start_i (fill_start_i),
    .fill_x0_i    (fill_x0_i),
    .fill_y0_i    (fill_y0_i),
    .fill_w_i     (fill_w_i),
    .fill_h_i     (fill_h_i),
    .fill_color_i (fill_color_i),
    .clear_i      (clear_i),
    .fill_busy_o  (fill_busy_o),
    .fill_done_o  (fill_done_o),
    .color_o      (color_o),
    .addr_x_o     (addr_x_o),
    .addr_y_o     (addr_y_o),
    .we_o         (we_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          exp_we = 1'b0, exp_ack = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic [CW-1:0] exp_x = '0, exp_y = '0;
  logic [1:0]    exp_color = '0;
  int  m_x0, m_y0, m_w, m_total, m_idx, m_color, px, py, pc;
  bit  m_last_cpu, m_ce, m_fe, m_gc, m_gf, n_busy, n_done;

  initial begin
    forever begin
      @(posedge clk or negedge arstn_i);
      if (!arstn_i) begin
        exp_we = 0; exp_ack = 0; exp_busy = 0; exp_done = 0;
        exp_x = '0; exp_y = '0; exp_color = '0;
        m_total = 0; m_idx = 0; m_last_cpu = 1;
      end else begin
        m_ce = cpu_req_i && !exp_ack;
        m_fe = exp_busy && (m_idx < m_total);
        m_gc = m_ce && (!m_fe || !m_last_cpu);
        m_gf = m_fe && !m_gc;
        n_busy = exp_busy && !exp_done;
        n_done = 0;
        px = 0; py = 0; pc = 0;
        if (m_gc) begin
          px = int'(cpu_x_i); py = int'(cpu_y_i); pc = int'(cpu_color_i);
          m_last_cpu = 1;
        end else if (m_gf) begin
          px = (m_x0 + m_idx % m_w) & MASK;
          py = (m_y0 + m_idx / m_w) & MASK;
          pc = m_color;
          m_idx++;
          if (m_idx == m_total) n_done = 1;
          m_last_cpu = 0;
        end
        if (!exp_busy && (clear_i || fill_start_i)) begin
          if (clear_i) begin
            m_x0 = 0; m_y0 = 0; m_w = HD; m_total = HD * VD; m_color = 0;
          end else begin
            m_x0 = int'(fill_x0_i); m_y0 = int'(fill_y0_i); m_w = int'(fill_w_i);
            m_total = int'(fill_w_i) * int'(fill_h_i); m_color = int'(fill_color_i);
          end
          m_idx = 0;
          n_busy = 1;
          if (m_total == 0) n_done = 1;
        end
        exp_we  = (m_gc || m_gf) && !(CLIP && (px >= HD || py >= VD));
        exp_ack = m_gc;
        if (m_gc || m_gf) begin
          exp_x = px[CW-1:0]; exp_y = py[CW-1:0]; exp_color = pc[1:0];
        end
        exp_busy = n_busy;
        exp_done = n_done;
      end
    end
  end

  // ---------------- compare process + write log ----------------
  typedef struct { bit ack; bit we; bit done; int x; int y; int c; } wr_t;
  wr_t wq[$];
  bit  cmp_en = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cycle_ctl", {we_o, cpu_ack_o, fill_busy_o, fill_done_o},
              {exp_we, exp_ack, exp_busy, exp_done});
        if (exp_we || exp_ack)
          check("cycle_data", {addr_x_o, addr_y_o, color_o}, {exp_x, exp_y, exp_color});
        if (we_o || cpu_ack_o)
          wq.push_back('{cpu_ack_o, we_o, fill_done_o, int'(addr_x_o), int'(addr_y_o), int'(color_o)});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h,
                            input int c, input bit clr);
    fill_x0_i = x0[CW-1:0]; fill_y0_i = y0[CW-1:0];
    fill_w_i = w[CW:0]; fill_h_i = h[CW:0]; fill_color_i = c[1:0];
    fill_start_i = 1'b1; clear_i = clr;
    step();
    fill_start_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!fill_done_o && n < bound) begin
      step();
      n++;
    end
    check("done_timeout", fill_done_o, 1);
  endtask

  task automatic cpu_write(input int x, input int y, input int c);
    int n = 0;
    cpu_x_i = x[CW-1:0]; cpu_y_i = y[CW-1:0]; cpu_color_i = c[1:0];
    cpu_req_i = 1'b1;
    step();
    while (!cpu_ack_o && n < 10) begin
      step();
      n++;
    end
    check("ack_timeout", cpu_ack_o, 1);
    step();  // request still held through the ack cycle
    cpu_req_i = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ex_x[6] = '{10, 11, 12, 10, 11, 12};
  int ex_y[6] = '{20, 20, 20, 21, 21, 21};

  initial begin
    int base, nf, nc, acks;
    logic [5:0] kinds;

    // Reset
    step(2);
    cmp_en = 1;
    step(2);
    arstn_i = 1'b1;
    check("reset_outputs", {we_o, cpu_ack_o, fill_busy_o, fill_done_o, color_o, addr_x_o, addr_y_o}, '0);
    step(2);

    // Single CPU write, request held into the ack cycle
    base = wq.size();
    cpu_write(5, 7, 1);
    step(2);
    check("cpu_write_count", wq.size() - base, 1);
    check("cpu_write_xy", {wq[base].x[15:0], wq[base].y[15:0]}, {16'd5, 16'd7});
    check("cpu_write_flags", {wq[base].we, wq[base].ack, wq[base].c[1:0]}, {1'b1, 1'b1, 2'd1});

    // 3x2 BLUE fill
    base = wq.size();
    start_fill(10, 20, 3, 2, 2, 0);
    wait_done(20);
    step();
    check("fill3x2_busy_after", fill_busy_o, 0);
    check("fill3x2_count", wq.size() - base, 6);
    if (wq.size() - base >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fill3x2_px%0d_xy", i), {wq[base+i].x[15:0], wq[base+i].y[15:0]},
              {ex_x[i][15:0], ex_y[i][15:0]});
        check($sformatf("fill3x2_px%0d_cd", i), {wq[base+i].c[1:0], wq[base+i].done},
              {2'd2, (i == 5) ? 1'b1 : 1'b0});
      end
    end
    step(2);

    // Contention: last grant was a CPU write, so the fill goes first
    cpu_write(100, 200, 3);
    step(2);
    base = wq.size();
    start_fill(30, 40, 4, 1, 1, 0);
    cpu_x_i = 11'd50; cpu_y_i = 11'd60; cpu_color_i = 2'd2;
    cpu_req_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      step();
      if (cpu_ack_o) acks++;
      if (acks == 2) cpu_req_i = 1'b0;
    end
    cpu_req_i = 1'b0;
    wait_done(20);
    step(3);
    nf = 0; nc = 0; kinds = '0;
    for (int i = base; i < wq.size(); i++) begin
      if (wq[i].ack) nc++; else nf++;
      if (i - base < 6) kinds[5 - (i - base)] = wq[i].ack;
    end
    check("contention_order", kinds, 6'b010100);
    check("contention_fill_count", nf, 4);
    check("contention_ack_count", nc, 2);

    // Empty rectangles
    base = wq.size();
    start_fill(3, 3, 0, 5, 1, 0);
    check("w0_done", {fill_done_o, fill_busy_o, we_o}, 3'b110);
    step();
    check("w0_after", {fill_done_o, fill_busy_o}, 2'b00);
    start_fill(3, 3, 5, 0, 1, 0);
    check("h0_done", {fill_done_o, fill_busy_o, we_o}, 3'b110);
    step();
    check("h0_after", {fill_done_o, fill_busy_o}, 2'b00);
    check("empty_no_writes", wq.size() - base, 0);

    // Off-screen CPU write
    base = wq.size();
    cpu_write(1280, 3, 2);
    check("oob_count", wq.size() - base, 1);
    check("oob_flags", {wq[base].ack, wq[base].we}, {1'b1, !CLIP});
    check("oob_x", wq[base].x, 1280);

    // Clear (wins over a simultaneous start), then reset mid-fill
    base = wq.size();
    start_fill(7, 7, 2, 2, 3, 1);
    step(10);
    check("clear_busy", fill_busy_o, 1);
    check("clear_px0", {wq[base].x[15:0], wq[base].y[15:0], wq[base].c[1:0]}, {16'd0, 16'd0, 2'd0});
    check("clear_px1", {wq[base+1].x[15:0], wq[base+1].y[15:0], wq[base+1].c[1:0]}, {16'd1, 16'd0, 2'd0});
    arstn_i = 1'b0;
    #1;
    check("midfill_reset", {we_o, cpu_ack_o, fill_busy_o, fill_done_o, color_o, addr_x_o, addr_y_o}, '0);
    step(3);
    arstn_i = 1'b1;
    base = wq.size();
    step(20);
    check("post_reset_idle", {fill_busy_o, fill_done_o, we_o}, 3'b000);
    check("post_reset_no_writes", wq.size() - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
